// File: rtl/types_pkg.sv
// rtl/types_pkg.sv - shared sizing types and loader FSM state encoding
package types_pkg;

   localparam int MEM_SIZE = 512;

   typedef logic [8:0]  address_t;
   typedef logic [31:0] word_t;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_COLLECT = 2'd1,
      ST_WRITE   = 2'd2,
      ST_DONE    = 2'd3
   } loader_state_t;

   // Largest legal word count, in the width of the len port
   localparam logic [9:0] LEN_MAX = 10'(MEM_SIZE);

   // A load request is legal for 1..MEM_SIZE words
   function automatic logic len_ok(input logic [9:0] l);
      return (l != 10'd0) && (l <= LEN_MAX);
   endfunction

endpackage

// File: rtl/imem_loader.sv
// rtl/imem_loader.sv - byte-stream to instruction-memory word loader with checksum
module imem_loader
   import types_pkg::*;
(
   input  logic        clk,
   input  logic        rst_n,
   input  logic        start,
   input  logic [9:0]  len,
   input  logic        abort,
   input  logic        in_valid,
   input  logic [7:0]  in_byte,
   output logic        in_ready,
   output logic        we,
   output address_t    waddr,
   output word_t       wdata,
   output logic        busy,
   output logic        done,
   output logic        err,
   output word_t       checksum
);

   loader_state_t state_q, state_d;
   logic [9:0]    len_q, len_d;
   logic [9:0]    word_cnt_q, word_cnt_d;
   logic [1:0]    byte_idx_q, byte_idx_d;
   word_t         asm_q, asm_d;
   word_t         checksum_q, checksum_d;
   logic          err_q, err_d;

   // Next-state logic: abort overrides everything, then the per-state behaviour
   always_comb begin
      state_d    = state_q;
      len_d      = len_q;
      word_cnt_d = word_cnt_q;
      byte_idx_d = byte_idx_q;
      asm_d      = asm_q;
      checksum_d = checksum_q;
      err_d      = err_q;

      if (abort) begin
         // Drop any partially assembled word; err and checksum are left alone
         state_d    = ST_IDLE;
         byte_idx_d = 2'd0;
         asm_d      = '0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (start) begin
                  if (len_ok(len)) begin
                     len_d      = len;
                     word_cnt_d = 10'd0;
                     byte_idx_d = 2'd0;
                     asm_d      = '0;
                     checksum_d = '0;
                     err_d      = 1'b0;
                     state_d    = ST_COLLECT;
                  end else begin
                     err_d = 1'b1;
                  end
               end
            end
            ST_COLLECT: begin
               // in_ready is high throughout COLLECT, so in_valid alone marks a transfer
               if (in_valid) begin
                  asm_d[{byte_idx_q, 3'b000} +: 8] = in_byte;
                  byte_idx_d = byte_idx_q + 2'd1;
                  if (byte_idx_q == 2'd3) begin
                     state_d = ST_WRITE;
                  end
               end
            end
            ST_WRITE: begin
               checksum_d = checksum_q + asm_q;
               if (word_cnt_q == len_q - 10'd1) begin
                  state_d = ST_DONE;
               end else begin
                  word_cnt_d = word_cnt_q + 10'd1;
                  state_d    = ST_COLLECT;
               end
            end
            ST_DONE: begin
               state_d = ST_IDLE;
            end
            default: begin
               state_d = ST_IDLE;
            end
         endcase
      end
   end

   // State, counters, assembly register and checksum
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= ST_IDLE;
         len_q      <= 10'd0;
         word_cnt_q <= 10'd0;
         byte_idx_q <= 2'd0;
         asm_q      <= '0;
         checksum_q <= '0;
         err_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         len_q      <= len_d;
         word_cnt_q <= word_cnt_d;
         byte_idx_q <= byte_idx_d;
         asm_q      <= asm_d;
         checksum_q <= checksum_d;
         err_q      <= err_d;
      end
   end

   // Outputs decode from state registers; abort masks the strobes in its own cycle
   always_comb begin
      in_ready = (state_q == ST_COLLECT) && !abort;
      we       = (state_q == ST_WRITE) && !abort;
      done     = (state_q == ST_DONE) && !abort;
      busy     = (state_q != ST_IDLE);
      waddr    = word_cnt_q[8:0];
      wdata    = asm_q;
      err      = err_q;
      checksum = checksum_q;
   end

endmodule

// File: tb/tb_imem_loader.sv
// tb/tb_imem_loader.sv - directed self-checking bench for imem_loader
module tb_imem_loader;
   import types_pkg::*;

   logic        clk;
   logic        rst_n;
   logic        start;
   logic [9:0]  len;
   logic        abort;
   logic        in_valid;
   logic [7:0]  in_byte;
   logic        in_ready;
   logic        we;
   address_t    waddr;
   word_t       wdata;
   logic        busy;
   logic        done;
   logic        err;
   word_t       checksum;

   int          n_checks = 0;
   int          n_fail   = 0;
   address_t    wa_q[$];
   word_t       wd_q[$];
   int          done_cnt = 0;

   imem_loader dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .start    (start),
      .len      (len),
      .abort    (abort),
      .in_valid (in_valid),
      .in_byte  (in_byte),
      .in_ready (in_ready),
      .we       (we),
      .waddr    (waddr),
      .wdata    (wdata),
      .busy     (busy),
      .done     (done),
      .err      (err),
      .checksum (checksum)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Record every write strobe and done pulse, sampled mid-cycle
   always @(negedge clk) begin
      if (rst_n && we) begin
         wa_q.push_back(waddr);
         wd_q.push_back(wdata);
      end
      if (rst_n && done) done_cnt++;
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_start(input logic [9:0] l);
      start = 1'b1;
      len   = l;
      step();
      start = 1'b0;
   endtask

   // Offer one byte and return #1 after the edge on which it transferred
   task automatic send_byte(input logic [7:0] b);
      int t;
      in_valid = 1'b1;
      in_byte  = b;
      t = 0;
      @(negedge clk);
      while (!in_ready && t < 20) begin
         @(negedge clk);
         t++;
      end
      if (!in_ready) check("handshake_timeout", {31'd0, in_ready}, 32'd1);
      @(posedge clk);
      #1;
      in_valid = 1'b0;
   endtask

   task automatic wait_idle(input string tag);
      int t;
      t = 0;
      @(negedge clk);
      while (busy && t < 50) begin
         @(negedge clk);
         t++;
      end
      check(tag, {31'd0, busy}, 32'd0);
      #1;
   endtask

   initial begin
      int base;
      int bad;
      int idx;
      int cyc;
      logic [7:0] rb [4];

      rst_n    = 1'b0;
      start    = 1'b0;
      len      = 10'd0;
      abort    = 1'b0;
      in_valid = 1'b0;
      in_byte  = 8'h00;

      // Reset state
      #12;
      check("rst_busy", {31'd0, busy}, 32'd0);
      check("rst_in_ready", {31'd0, in_ready}, 32'd0);
      check("rst_we", {31'd0, we}, 32'd0);
      check("rst_done", {31'd0, done}, 32'd0);
      check("rst_err", {31'd0, err}, 32'd0);
      check("rst_waddr", {23'd0, waddr}, 32'd0);
      check("rst_wdata", wdata, 32'd0);
      check("rst_checksum", checksum, 32'd0);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      step();

      // Two-word load: latency of we and in_ready return
      do_start(10'd2);
      check("t1_busy", {31'd0, busy}, 32'd1);
      send_byte(8'h13);
      send_byte(8'h00);
      send_byte(8'h00);
      send_byte(8'h00);
      check("t1_we_lat", {31'd0, we}, 32'd1);
      check("t1_waddr0", {23'd0, waddr}, 32'd0);
      check("t1_wdata0", wdata, 32'h0000_0013);
      check("t1_ready_low", {31'd0, in_ready}, 32'd0);
      step();
      check("t1_ready_back", {31'd0, in_ready}, 32'd1);
      check("t1_we_once", {31'd0, we}, 32'd0);
      send_byte(8'h93);
      send_byte(8'h00);
      send_byte(8'h10);
      send_byte(8'h00);
      check("t1_waddr1", {23'd0, waddr}, 32'd1);
      check("t1_wdata1", wdata, 32'h0010_0093);
      step();
      check("t1_done", {31'd0, done}, 32'd1);
      step();
      check("t1_done_pulse", {31'd0, done}, 32'd0);
      check("t1_idle", {31'd0, busy}, 32'd0);
      check("t1_checksum", checksum, 32'h0010_00A6);
      check("t1_nwrites", wa_q.size(), 32'd2);
      check("t1_mon_d1", wd_q[1], 32'h0010_0093);
      check("t1_done_cnt", done_cnt, 32'd1);

      // Illegal lengths set err without leaving IDLE
      do_start(10'd0);
      check("t2_err0", {31'd0, err}, 32'd1);
      check("t2_busy0", {31'd0, busy}, 32'd0);
      step();
      do_start(10'd600);
      check("t2_err600", {31'd0, err}, 32'd1);
      check("t2_busy600", {31'd0, busy}, 32'd0);
      step();
      check("t2_nowrite", wa_q.size(), 32'd2);
      do_start(10'd1);
      check("t2_err_clr", {31'd0, err}, 32'd0);
      check("t2_busy1", {31'd0, busy}, 32'd1);

      // One word with a randomly gapped in_valid; idle bytes must not be consumed
      rb[0] = 8'h11; rb[1] = 8'h22; rb[2] = 8'h33; rb[3] = 8'h44;
      idx = 0;
      cyc = 0;
      while (idx < 4 && cyc < 200) begin
         in_valid = 1'($urandom_range(0, 1));
         in_byte  = in_valid ? rb[idx] : 8'hEE;
         @(negedge clk);
         if (in_valid && in_ready) idx++;
         @(posedge clk);
         #1;
         cyc++;
      end
      in_valid = 1'b0;
      check("t3_all_bytes", idx, 32'd4);
      wait_idle("t3_idle");
      check("t3_nwrites", wa_q.size(), 32'd3);
      check("t3_addr", {23'd0, wa_q[2]}, 32'd0);
      check("t3_data", wd_q[2], 32'h4433_2211);
      check("t3_checksum", checksum, 32'h4433_2211);
      check("t3_done_cnt", done_cnt, 32'd2);

      // Abort partway through the second word of a three-word load
      do_start(10'd3);
      for (int i = 1; i <= 6; i++) send_byte(8'(i));
      abort    = 1'b1;
      in_valid = 1'b1;
      in_byte  = 8'h07;
      #1;
      check("t4_ready_abort", {31'd0, in_ready}, 32'd0);
      step();
      abort    = 1'b0;
      in_valid = 1'b0;
      check("t4_idle", {31'd0, busy}, 32'd0);
      step();
      step();
      check("t4_nwrites", wa_q.size(), 32'd4);
      check("t4_addr", {23'd0, wa_q[3]}, 32'd0);
      check("t4_data", wd_q[3], 32'h0403_0201);
      check("t4_no_done", done_cnt, 32'd2);
      do_start(10'd1);
      send_byte(8'hAA);
      send_byte(8'hBB);
      send_byte(8'hCC);
      send_byte(8'hDD);
      wait_idle("t4_reload_idle");
      check("t4_reload_n", wa_q.size(), 32'd5);
      check("t4_reload_addr", {23'd0, wa_q[4]}, 32'd0);
      check("t4_reload_data", wd_q[4], 32'hDDCC_BBAA);
      check("t4_reload_cks", checksum, 32'hDDCC_BBAA);

      // Full-size load of all-ones words
      base = wa_q.size();
      do_start(10'd512);
      for (int i = 0; i < 2048; i++) send_byte(8'hFF);
      wait_idle("t5_idle");
      check("t5_nwrites", wa_q.size() - base, 32'd512);
      bad = 0;
      for (int i = 0; i < 512; i++) begin
         if (base + i < wa_q.size()) begin
            if (wa_q[base + i] !== 9'(i) || wd_q[base + i] !== 32'hFFFF_FFFF) bad++;
         end
      end
      check("t5_addr_data", bad, 32'd0);
      check("t5_checksum", checksum, 32'hFFFF_FE00);
      check("t5_done_cnt", done_cnt, 32'd4);

      // Asynchronous reset in the middle of COLLECT
      base = wa_q.size();
      do_start(10'd2);
      send_byte(8'h55);
      send_byte(8'h66);
      #2;
      rst_n = 1'b0;
      #1;
      check("t6_busy", {31'd0, busy}, 32'd0);
      check("t6_in_ready", {31'd0, in_ready}, 32'd0);
      check("t6_we", {31'd0, we}, 32'd0);
      check("t6_wdata", wdata, 32'd0);
      check("t6_waddr", {23'd0, waddr}, 32'd0);
      check("t6_checksum", checksum, 32'd0);
      check("t6_err", {31'd0, err}, 32'd0);
      check("t6_done", {31'd0, done}, 32'd0);
      step();
      rst_n    = 1'b1;
      in_valid = 1'b1;
      in_byte  = 8'h77;
      for (int i = 0; i < 10; i++) step();
      in_valid = 1'b0;
      check("t6_no_write", wa_q.size() - base, 32'd0);
      check("t6_still_idle", {31'd0, busy}, 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
